pf_iod_read_train_ctrl: RTL and testbench
=========================================

// Module: pf_iod_read_train_ctrl
// PURPOSE
//  Sequences the per-lane IOD read-training delay line for the DDR3 PHY. On start it loads tap 0,
//  sweeps the delay line upward one tap at a time and grades each tap with the IOD eye monitor.
//  It then finds the longest contiguous passing window, steps the delay line back to the window
//  centre, and reports done or fail. One instance per DQ lane, in the FAB_CLK domain.
// PARAMETERS
//  TAP_W       8    width of the tap counter and of the tap outputs
//  MAX_TAP     127  last tap graded in a sweep; must be < 2**TAP_W
//  SETTLE_CYC  4    idle cycles after each flag clear or move before sampling starts (>=2)
//  DWELL_CYC   16   cycles the eye-monitor flags are observed per tap (>=1)
//  MIN_WIN     8    minimum passing window width in taps; below this the sweep fails
// PORTS
//  FAB_CLK        in   1      fabric clock; every output is registered on it
//  ARST           in   1      asynchronous, active-high reset
//  start          in   1      1-cycle request; accepted only in IDLE, DONE or FAIL
//  em_early       in   1      IOD EYE_MONITOR_EARLY
//  em_late        in   1      IOD EYE_MONITOR_LATE
//  dl_oor         in   1      IOD DELAY_LINE_OUT_OF_RANGE
//  dl_load        out  1      1-cycle pulse to IOD DELAY_LINE_LOAD (delay line to tap 0)
//  dl_move        out  1      1-cycle pulse to IOD DELAY_LINE_MOVE
//  dl_dir         out  1      IOD DELAY_LINE_DIRECTION; 1=increment, 0=decrement; held across moves
//  em_clear       out  1      1-cycle pulse to IOD EYE_MONITOR_CLEAR_FLAGS
//  busy           out  1      high from start acceptance until DONE or FAIL is entered
//  done           out  1      level; high in DONE
//  fail           out  1      level; high in FAIL
//  center_tap     out  TAP_W  final tap; valid while done=1
//  win_width      out  TAP_W  width of the longest passing window; valid in DONE and FAIL
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, all counters 0. A reset mid-sweep abandons the sweep; the
//   next start reloads tap 0, so the delay line position is never trusted across a reset.
//  FSM: IDLE -start-> LOAD(dl_load=1, tap=0, dl_dir=1) -> CLEAR(em_clear=1) -> SETTLE(SETTLE_CYC)
//   -> SAMPLE(DWELL_CYC; OR-accumulate em_early|em_late) -> GRADE -> STEP(dl_move=1, tap+1)
//   -> CLEAR ... GRADE goes to CALC when tap==MAX_TAP or dl_oor=1 was seen during SAMPLE.
//   CALC -> CENTER (dl_dir=0; while tap>center: dl_move=1, tap-1, then 2 gap cycles) -> DONE.
//   CALC -> FAIL if best window < MIN_WIN.
//  Grading: a tap passes when no early or late flag was seen during its dwell. A run opens on the
//   first passing tap and closes on the first failing tap. A run still open at sweep end is closed
//   at the last graded tap. The best window is replaced only by a strictly longer run, so the
//   first window wins a tie.
//  Centre: window s..e, len=e-s+1, centre = s + ((len-1)>>1) (floor). The controller issues
//   (tap - centre) decrement pulses; zero pulses if tap==centre.
//  dl_oor during SAMPLE: the current tap is graded fail, the sweep ends, and no further increment
//   is issued.
//  Pulse spacing: consecutive dl_move pulses are at least 3 cycles apart. dl_load, dl_move and
//   em_clear are never high in the same cycle.
//  start latency: start in cycle N produces dl_load=1 in cycle N+1. start while busy is ignored.
//   start in DONE/FAIL clears done/fail, win_width and center_tap in the next cycle and restarts.
// CONFIGURATION
//  IOD_TRAIN_LOG_EN defined: adds outputs log_valid(1), log_tap(TAP_W), log_pass(1).
//   log_valid pulses once per GRADE, with the tap just graded and its verdict. Reset value 0.
//  IOD_TRAIN_LOG_EN undefined: these ports and their registers do not exist; all other behaviour
//   is identical.
// TESTING
//  1. Flags clear at taps 20..59 only, MAX_TAP=127 -> win_width=40, center_tap=39, done=1,
//     88 decrement pulses issued.
//  2. Windows 10..17 and 30..37 (equal, 8 taps) -> first window chosen, center_tap=13.
//  3. Flags clear at taps 0..5 only -> win_width=6 < MIN_WIN -> fail=1, done=0, no decrement
//     pulses issued.
//  4. Pass from tap 100 onward, dl_oor=1 at tap 110 -> sweep stops without a move, window 100..109,
//     center_tap=104.
//  5. ARST asserted during SAMPLE at tap 50 -> all outputs 0 immediately. A new start produces
//     dl_load the next cycle and the full sweep repeats.
//  6. start pulsed while busy -> ignored. Check the dl_move spacing rule and the exclusivity of
//     dl_load, dl_move and em_clear over the whole sweep.

Source files
------------

// File: rtl/pf_iod_read_train_ctrl.sv
// Per-lane IOD read-training controller: sweeps the delay line, finds the widest passing eye window, recentres on it.
// Optional IOD_TRAIN_LOG_EN adds a per-tap grading log (log_valid/log_tap/log_pass).
module pf_iod_read_train_ctrl #(
   parameter int TAP_W      = 8,
   parameter int MAX_TAP    = 127,
   parameter int SETTLE_CYC = 4,
   parameter int DWELL_CYC  = 16,
   parameter int MIN_WIN    = 8
) (
   input  logic             FAB_CLK,
   input  logic             ARST,
   input  logic             start,
   input  logic             em_early,
   input  logic             em_late,
   input  logic             dl_oor,
   output logic             dl_load,
   output logic             dl_move,
   output logic             dl_dir,
   output logic             em_clear,
   output logic             busy,
   output logic             done,
   output logic             fail,
`ifdef IOD_TRAIN_LOG_EN
   output logic             log_valid,
   output logic [TAP_W-1:0] log_tap,
   output logic             log_pass,
`endif
   output logic [TAP_W-1:0] center_tap,
   output logic [TAP_W-1:0] win_width
);

   localparam int LW      = TAP_W + 1;
   localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, LOAD, CLEAR, SETTLE, SAMPLE, GRADE, STEP, CALC, CENTER, DONE, FAIL
   } state_t;

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [TAP_W-1:0] r_tap, r_runStart, r_bestStart, r_centre;
   logic [LW-1:0]    r_bestLen;
   logic             r_runOpen, r_flag, r_oor;

   logic             w_pass, w_last, w_centerMove, w_move, w_candValid;
   logic [TAP_W-1:0] w_curStart, w_candStart;
   logic [LW-1:0]    w_candLen;

   assign w_pass       = !r_flag && !r_oor;
   assign w_last       = (r_tap == TAP_W'(MAX_TAP)) || r_oor;
   assign w_curStart   = r_runOpen ? r_runStart : r_tap;
   assign w_centerMove = (r_cnt == '0) && (r_tap > r_centre);

   // A run that is still open is closed at the current tap on the last grade, or one tap back on a failing grade.
   always_comb begin
      w_candValid = 1'b0;
      w_candLen   = '0;
      w_candStart = '0;
      if (w_pass) begin
         if (w_last) begin
            w_candValid = 1'b1;
            w_candLen   = LW'(r_tap) - LW'(w_curStart) + LW'(1);
            w_candStart = w_curStart;
         end
      end else if (r_runOpen) begin
         w_candValid = 1'b1;
         w_candLen   = LW'(r_tap) - LW'(r_runStart);
         w_candStart = r_runStart;
      end
   end

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, FAIL: if (start) w_next = LOAD;
         LOAD:   w_next = CLEAR;
         CLEAR:  w_next = SETTLE;
         SETTLE: if (r_cnt == CNT_W'(SETTLE_CYC - 1)) w_next = SAMPLE;
         SAMPLE: if (r_cnt == CNT_W'(DWELL_CYC - 1)) w_next = GRADE;
         GRADE:  w_next = w_last ? CALC : STEP;
         STEP:   w_next = CLEAR;
         CALC:   w_next = (r_bestLen < LW'(MIN_WIN)) ? FAIL : CENTER;
         CENTER: if ((r_cnt == '0) && !(r_tap > r_centre)) w_next = DONE;
         default: w_next = IDLE;
      endcase
      w_move = (w_next == STEP) || ((r_state == CENTER) && w_centerMove);
   end

   // Sweep datapath: dwell counters, flag accumulation, run tracking and the centring walk.
   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         r_cnt       <= '0;
         r_tap       <= '0;
         r_runStart  <= '0;
         r_runOpen   <= 1'b0;
         r_bestStart <= '0;
         r_bestLen   <= '0;
         r_centre    <= '0;
         r_flag      <= 1'b0;
         r_oor       <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_cnt  <= '0;
               r_flag <= 1'b0;
               r_oor  <= 1'b0;
            end
            SETTLE: r_cnt <= (w_next == SAMPLE) ? '0 : r_cnt + 1'b1;
            SAMPLE: begin
               r_cnt  <= (w_next == GRADE) ? '0 : r_cnt + 1'b1;
               r_flag <= r_flag | em_early | em_late;
               r_oor  <= r_oor | dl_oor;
            end
            GRADE: begin
               r_cnt     <= '0;
               r_runOpen <= w_pass && !w_last;
               if (w_pass) r_runStart <= w_curStart;
               if (w_candValid && (w_candLen > r_bestLen)) begin
                  r_bestLen   <= w_candLen;
                  r_bestStart <= w_candStart;
               end
               if (w_next == STEP) r_tap <= r_tap + 1'b1;
            end
            CALC: begin
               r_cnt    <= '0;
               r_centre <= r_bestStart + TAP_W'((r_bestLen - LW'(1)) >> 1);
            end
            CENTER: begin
               if (w_centerMove) begin
                  r_cnt <= CNT_W'(2);
                  r_tap <= r_tap - 1'b1;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
         if (w_next == LOAD) begin
            r_tap       <= '0;
            r_runOpen   <= 1'b0;
            r_runStart  <= '0;
            r_bestLen   <= '0;
            r_bestStart <= '0;
         end
      end
   end

   // Outputs are registered from the next state so each pulse lines up with the state it belongs to.
   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         dl_load    <= 1'b0;
         dl_move    <= 1'b0;
         dl_dir     <= 1'b0;
         em_clear   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         center_tap <= '0;
         win_width  <= '0;
`ifdef IOD_TRAIN_LOG_EN
         log_valid  <= 1'b0;
         log_tap    <= '0;
         log_pass   <= 1'b0;
`endif
      end else begin
         dl_load  <= (w_next == LOAD);
         dl_move  <= w_move;
         em_clear <= (w_next == CLEAR);
         busy     <= !((w_next == IDLE) || (w_next == DONE) || (w_next == FAIL));
         done     <= (w_next == DONE);
         fail     <= (w_next == FAIL);
         if (w_next == LOAD)                             dl_dir <= 1'b1;
         else if ((r_state == CALC) && (w_next == CENTER)) dl_dir <= 1'b0;
         if (w_next == LOAD) begin
            win_width  <= '0;
            center_tap <= '0;
         end else begin
            if (r_state == CALC) win_width <= TAP_W'(r_bestLen);
            if ((r_state == CENTER) && (w_next == DONE)) center_tap <= r_tap;
         end
`ifdef IOD_TRAIN_LOG_EN
         log_valid <= (r_state == GRADE);
         if (r_state == GRADE) begin
            log_tap  <= r_tap;
            log_pass <= w_pass;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pf_iod_read_train_ctrl.sv
// Directed bench for pf_iod_read_train_ctrl: models the IOD delay line and eye monitor, checks windows and pulse rules.
module tb_pf_iod_read_train_ctrl;

   logic       FAB_CLK = 1'b0;
   logic       ARST    = 1'b1;
   logic       start   = 1'b0;
   logic       em_early, em_late, dl_oor;
   logic       dl_load, dl_move, dl_dir, em_clear, busy, done, fail;
   logic [7:0] center_tap, win_width;

   int checks = 0;
   int errors = 0;

   int modelTap  = 0;
   int cycle     = 0;
   int loadCount = 0;
   int incCount  = 0;
   int decCount  = 0;
   int lastMove  = -100;
   int spaceViol = 0;
   int exclViol  = 0;

   int w0Lo = -1, w0Hi = -1, w1Lo = -1, w1Hi = -1, oorTap = -1;
   logic inWin;

   pf_iod_read_train_ctrl dut (
      .FAB_CLK   (FAB_CLK),
      .ARST      (ARST),
      .start     (start),
      .em_early  (em_early),
      .em_late   (em_late),
      .dl_oor    (dl_oor),
      .dl_load   (dl_load),
      .dl_move   (dl_move),
      .dl_dir    (dl_dir),
      .em_clear  (em_clear),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .center_tap(center_tap),
      .win_width (win_width)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   // Failing taps raise a flag only every fifth cycle so the whole dwell must be observed.
   assign inWin    = ((modelTap >= w0Lo) && (modelTap <= w0Hi)) || ((modelTap >= w1Lo) && (modelTap <= w1Hi));
   assign em_early = !inWin && ((cycle % 5) == 0) && ((modelTap % 2) == 0);
   assign em_late  = !inWin && ((cycle % 5) == 0) && ((modelTap % 2) == 1);
   assign dl_oor   = (modelTap == oorTap);

   // Delay-line model plus pulse-rule monitors.
   always @(posedge FAB_CLK) begin
      cycle <= cycle + 1;
      if (dl_load) begin
         modelTap  <= 0;
         loadCount <= loadCount + 1;
      end else if (dl_move) begin
         modelTap <= dl_dir ? modelTap + 1 : modelTap - 1;
      end
      if (dl_move && dl_dir)  incCount <= incCount + 1;
      if (dl_move && !dl_dir) decCount <= decCount + 1;
      if (dl_move) begin
         if (cycle - lastMove < 3) spaceViol <= spaceViol + 1;
         lastMove <= cycle;
      end
      if (int'(dl_load) + int'(dl_move) + int'(em_clear) > 1) exclViol <= exclViol + 1;
   end

   task automatic applyStimulus(input int a0, input int a1, input int b0, input int b1, input int oor);
      w0Lo = a0; w0Hi = a1; w1Lo = b0; w1Hi = b1; oorTap = oor;
      @(negedge FAB_CLK);
      start = 1'b1;
      @(negedge FAB_CLK);
      start = 1'b0;
      checks++;
      if (dl_load !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || win_width !== 8'd0) begin
         errors++;
         $display("[TB] FAIL start_latency: dl_load=%b busy=%b done=%b win_width=%0d, expected 1 1 0 0",
                  dl_load, busy, done, win_width);
      end
   endtask

   task automatic waitEnd(input string name);
      int n;
      n = 0;
      while (!(done || fail) && n < 8000) begin
         @(negedge FAB_CLK);
         n++;
      end
      checks++;
      if (!(done || fail)) begin
         errors++;
         $display("[TB] FAIL %s_timeout: done=%b fail=%b after %0d cycles, expected completion", name, done, fail, n);
      end
   endtask

   task automatic test_reset();
      ARST = 1'b1;
      repeat (3) @(negedge FAB_CLK);
      checks++;
      if ({dl_load, dl_move, dl_dir, em_clear, busy, done, fail, center_tap, win_width} !== 23'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h, expected 0",
                  {dl_load, dl_move, dl_dir, em_clear, busy, done, fail, center_tap, win_width});
      end
      ARST = 1'b0;
      repeat (4) @(negedge FAB_CLK);
      checks++;
      if ({dl_load, busy, done, fail} !== 4'd0) begin
         errors++;
         $display("[TB] FAIL idle_quiet: load/busy/done/fail=%b, expected 0000", {dl_load, busy, done, fail});
      end
   endtask

   task automatic test_wide_window();
      int inc0, dec0;
      inc0 = incCount; dec0 = decCount;
      applyStimulus(20, 59, -1, -1, -1);
      waitEnd("wide");
      checks++;
      if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wide_status: done=%b fail=%b busy=%b, expected 1 0 0", done, fail, busy);
      end
      checks++;
      if (win_width !== 8'd40) begin
         errors++;
         $display("[TB] FAIL wide_width: got %0d, expected 40", win_width);
      end
      checks++;
      if (center_tap !== 8'd39 || modelTap != 39) begin
         errors++;
         $display("[TB] FAIL wide_center: center_tap=%0d line=%0d, expected 39 39", center_tap, modelTap);
      end
      checks++;
      if (decCount - dec0 != 88 || incCount - inc0 != 127) begin
         errors++;
         $display("[TB] FAIL wide_pulses: dec=%0d inc=%0d, expected 88 127", decCount - dec0, incCount - inc0);
      end
   endtask

   task automatic test_tie();
      int dec0;
      dec0 = decCount;
      applyStimulus(10, 17, 30, 37, -1);
      waitEnd("tie");
      checks++;
      if (done !== 1'b1 || win_width !== 8'd8 || center_tap !== 8'd13) begin
         errors++;
         $display("[TB] FAIL tie_first_window: done=%b width=%0d center=%0d, expected 1 8 13", done, win_width, center_tap);
      end
      checks++;
      if (decCount - dec0 != 114) begin
         errors++;
         $display("[TB] FAIL tie_dec_pulses: got %0d, expected 114", decCount - dec0);
      end
   endtask

   task automatic test_narrow();
      int dec0;
      dec0 = decCount;
      applyStimulus(0, 5, -1, -1, -1);
      waitEnd("narrow");
      checks++;
      if (fail !== 1'b1 || done !== 1'b0 || win_width !== 8'd6) begin
         errors++;
         $display("[TB] FAIL narrow_fail: fail=%b done=%b width=%0d, expected 1 0 6", fail, done, win_width);
      end
      checks++;
      if (decCount - dec0 != 0 || dl_dir !== 1'b1) begin
         errors++;
         $display("[TB] FAIL narrow_no_dec: dec=%0d dir=%b, expected 0 1", decCount - dec0, dl_dir);
      end
   endtask

   task automatic test_oor();
      int inc0, dec0;
      inc0 = incCount; dec0 = decCount;
      applyStimulus(100, 200, -1, -1, 110);
      waitEnd("oor");
      checks++;
      if (done !== 1'b1 || win_width !== 8'd10 || center_tap !== 8'd104) begin
         errors++;
         $display("[TB] FAIL oor_window: done=%b width=%0d center=%0d, expected 1 10 104", done, win_width, center_tap);
      end
      checks++;
      if (incCount - inc0 != 110 || decCount - dec0 != 6) begin
         errors++;
         $display("[TB] FAIL oor_pulses: inc=%0d dec=%0d, expected 110 6", incCount - inc0, decCount - dec0);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n, inc0;
      applyStimulus(20, 59, -1, -1, -1);
      n = 0;
      while (modelTap != 50 && n < 4000) begin
         @(negedge FAB_CLK);
         n++;
      end
      repeat (8) @(negedge FAB_CLK);
      checks++;
      if (busy !== 1'b1 || modelTap != 50) begin
         errors++;
         $display("[TB] FAIL mid_reach_tap50: busy=%b line=%0d, expected 1 50", busy, modelTap);
      end
      #2 ARST = 1'b1;
      #1;
      checks++;
      if ({dl_load, dl_move, dl_dir, em_clear, busy, done, fail, center_tap, win_width} !== 23'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_async: got %h, expected 0",
                  {dl_load, dl_move, dl_dir, em_clear, busy, done, fail, center_tap, win_width});
      end
      @(negedge FAB_CLK);
      ARST = 1'b0;
      @(negedge FAB_CLK);
      inc0 = incCount;
      applyStimulus(20, 59, -1, -1, -1);
      waitEnd("mid_resweep");
      checks++;
      if (done !== 1'b1 || win_width !== 8'd40 || center_tap !== 8'd39 || incCount - inc0 != 127) begin
         errors++;
         $display("[TB] FAIL mid_resweep: done=%b width=%0d center=%0d inc=%0d, expected 1 40 39 127",
                  done, win_width, center_tap, incCount - inc0);
      end
   endtask

   task automatic test_back_to_back();
      int load0;
      load0 = loadCount;
      applyStimulus(64, 90, -1, -1, -1);
      for (int k = 0; k < 3; k++) begin
         repeat (400 + 37 * k) @(negedge FAB_CLK);
         start = 1'b1;
         @(negedge FAB_CLK);
         start = 1'b0;
      end
      waitEnd("b2b");
      checks++;
      if (loadCount - load0 != 1 || done !== 1'b1 || win_width !== 8'd27 || center_tap !== 8'd77) begin
         errors++;
         $display("[TB] FAIL b2b_ignore_start: loads=%0d done=%b width=%0d center=%0d, expected 1 1 27 77",
                  loadCount - load0, done, win_width, center_tap);
      end
      applyStimulus(64, 90, -1, -1, -1);
      checks++;
      if (center_tap !== 8'd0 || fail !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_restart_clear: center=%0d fail=%b, expected 0 0", center_tap, fail);
      end
      waitEnd("b2b_restart");
      checks++;
      if (done !== 1'b1 || center_tap !== 8'd77) begin
         errors++;
         $display("[TB] FAIL b2b_restart_result: done=%b center=%0d, expected 1 77", done, center_tap);
      end
      checks++;
      if (spaceViol != 0 || exclViol != 0) begin
         errors++;
         $display("[TB] FAIL pulse_rules: spacing=%0d exclusivity=%0d violations, expected 0 0", spaceViol, exclViol);
      end
   endtask

   initial begin
      test_reset();
      test_wide_window();
      test_tie();
      test_narrow();
      test_oor();
      test_reset_mid_sweep();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
